// File: rtl/cache_block_memory_pkg.sv
// Shared cache/memory constants: block geometry, address fields and responder states.
package cache_block_memory_pkg;

    localparam int unsigned CACHE_WORD_W      = 32;
    localparam int unsigned CACHE_BLOCK_WORDS = 4;
    localparam int unsigned CACHE_BLOCK_W     = CACHE_WORD_W * CACHE_BLOCK_WORDS;
    localparam int unsigned CACHE_MEM_ADDR_W  = 28;

    // CPU address fields: byte+word offset, set index, tag.
    localparam int unsigned OFFSET_LSB = 0;
    localparam int unsigned OFFSET_W   = 4;
    localparam int unsigned INDEX_LSB  = OFFSET_LSB + OFFSET_W;
    localparam int unsigned INDEX_W    = 3;
    localparam int unsigned TAG_LSB    = INDEX_LSB + INDEX_W;
    localparam int unsigned TAG_W      = 32 - TAG_LSB;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } mem_state_e;

endpackage

// File: rtl/block_mem_array.sv
// Block storage: synchronous write, asynchronous read, entries start as the 4*i+w pattern.
module block_mem_array #(
    parameter int unsigned WORD_W      = 32,
    parameter int unsigned BLOCK_WORDS = 4,
    parameter int unsigned DEPTH       = 256
) (
    input  logic                                  clk,
    input  logic                                  we,
    input  logic [$clog2(DEPTH)-1:0]              waddr,
    input  logic [WORD_W*BLOCK_WORDS-1:0]         wdata,
    input  logic [$clog2(DEPTH)-1:0]              raddr,
    output logic [WORD_W*BLOCK_WORDS-1:0]         rdata
);

    localparam int unsigned BLOCK_W = WORD_W * BLOCK_WORDS;
    localparam int unsigned IDX_W   = $clog2(DEPTH);

    logic [BLOCK_W-1:0] mem [DEPTH];
    // Entries never written read back the power-up pattern instead of storage.
    logic [DEPTH-1:0]   written = '0;

    function automatic logic [BLOCK_W-1:0] init_block(input logic [IDX_W-1:0] idx);
        logic [BLOCK_W-1:0] blk;
        blk = '0;
        for (int unsigned w = 0; w < BLOCK_WORDS; w++) begin
            blk[w*WORD_W +: WORD_W] = WORD_W'(BLOCK_WORDS * 32'(idx) + w);
        end
        return blk;
    endfunction

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr]     <= wdata;
            written[waddr] <= 1'b1;
        end
    end

    assign rdata = written[raddr] ? mem[raddr] : init_block(raddr);

endmodule

// File: rtl/cache_block_memory.sv
// Refill-side main memory: whole-block read/write with busywait handshake and fixed latency.
module cache_block_memory
    import cache_block_memory_pkg::*;
#(
    parameter int unsigned WORD_W      = CACHE_WORD_W,
    parameter int unsigned BLOCK_WORDS = CACHE_BLOCK_WORDS,
    parameter int unsigned MEM_ADDR_W  = CACHE_MEM_ADDR_W,
    parameter int unsigned DEPTH       = 256,
    parameter int unsigned LATENCY     = 5
) (
    input  logic                              clk,
    input  logic                              reset,
    input  logic                              mem_read,
    input  logic                              mem_write,
    input  logic [MEM_ADDR_W-1:0]             mem_address,
    input  logic [WORD_W*BLOCK_WORDS-1:0]     mem_writedata,
    output logic [WORD_W*BLOCK_WORDS-1:0]     mem_readdata,
    output logic                              mem_busywait
);

    localparam int unsigned BLOCK_W = WORD_W * BLOCK_WORDS;
    localparam int unsigned IDX_W   = $clog2(DEPTH);

    mem_state_e           state_q, state_d;
    logic [3:0]           cnt_q, cnt_d;
    logic                 op_write_q;
    logic [IDX_W-1:0]     idx_q;
    logic [BLOCK_W-1:0]   data_q;
    logic [BLOCK_W-1:0]   arr_rdata;
    logic                 capture, rd_done, wr_en;

    // Upper address bits only alias onto the array.
    if (MEM_ADDR_W > IDX_W) begin : g_alias
        logic unused_addr_hi;
        assign unused_addr_hi = ^mem_address[MEM_ADDR_W-1:IDX_W];
    end

    assign mem_busywait = (state_q == IDLE && (mem_read || mem_write)) || state_q == BUSY;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            op_write_q   <= 1'b0;
            idx_q        <= '0;
            data_q       <= '0;
            mem_readdata <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (capture) begin
                op_write_q <= mem_write;
                idx_q      <= mem_address[IDX_W-1:0];
                data_q     <= mem_writedata;
            end
            if (rd_done) begin
                mem_readdata <= arr_rdata;
            end
        end
    end

    // Write wins when both request lines are high; completion fires when cnt reaches zero.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        capture = 1'b0;
        rd_done = 1'b0;
        wr_en   = 1'b0;
        case (state_q)
            IDLE: begin
                if (mem_read || mem_write) begin
                    capture = 1'b1;
                    cnt_d   = 4'(LATENCY - 1);
                    state_d = BUSY;
                end
            end
            BUSY: begin
                if (cnt_q != 4'd0) begin
                    cnt_d = cnt_q - 4'd1;
                end else begin
                    rd_done = !op_write_q;
                    wr_en   = op_write_q;
                    state_d = DONE;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    block_mem_array #(
        .WORD_W      (WORD_W),
        .BLOCK_WORDS (BLOCK_WORDS),
        .DEPTH       (DEPTH)
    ) u_array (
        .clk   (clk),
        .we    (wr_en),
        .waddr (idx_q),
        .wdata (data_q),
        .raddr (idx_q),
        .rdata (arr_rdata)
    );

endmodule

// File: tb/tb_cache_block_memory.sv
// Randomized bench for cache_block_memory against an array-and-latency reference model.
module tb_cache_block_memory;

    localparam int unsigned LAT   = 5;
    localparam int unsigned DEPTH = 256;

    logic         clk = 1'b0;
    logic         reset = 1'b0;
    logic         mem_read = 1'b0;
    logic         mem_write = 1'b0;
    logic [27:0]  mem_address = '0;
    logic [127:0] mem_writedata = '0;
    logic [127:0] mem_readdata;
    logic         mem_busywait;

    int checks = 0;
    int errors = 0;

    logic [127:0] ref_mem [DEPTH];
    logic [127:0] ref_rdata;

    cache_block_memory #(
        .WORD_W      (32),
        .BLOCK_WORDS (4),
        .MEM_ADDR_W  (28),
        .DEPTH       (DEPTH),
        .LATENCY     (LAT)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .mem_read      (mem_read),
        .mem_write     (mem_write),
        .mem_address   (mem_address),
        .mem_writedata (mem_writedata),
        .mem_readdata  (mem_readdata),
        .mem_busywait  (mem_busywait)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [127:0] pattern(input int i);
        return {32'(4*i+3), 32'(4*i+2), 32'(4*i+1), 32'(4*i)};
    endfunction

    // One full transaction: request at a negedge, capture edge E0, completion at E0+LAT, IDLE at E0+LAT+1.
    task automatic txn(input bit rd, input bit wr, input logic [27:0] a, input logic [127:0] d,
                       input bit hold, input bit scramble);
        int idx;
        logic [127:0] old;
        idx = int'(a[7:0]);
        old = ref_rdata;
        @(negedge clk);
        mem_read = rd; mem_write = wr; mem_address = a; mem_writedata = d;
        #1 check("busy_rise", {127'd0, mem_busywait}, 128'd1);
        @(posedge clk);
        if (wr) ref_mem[idx] = d;
        else    ref_rdata = ref_mem[idx];
        for (int k = 1; k <= int'(LAT); k++) begin
            @(negedge clk);
            if (scramble) begin
                mem_address   = 28'($urandom());
                mem_writedata = {$urandom(), $urandom(), $urandom(), $urandom()};
                mem_read      = 1'($urandom());
                mem_write     = 1'($urandom());
            end
            @(posedge clk);
            #1;
            if (k < int'(LAT)) begin
                check("busy_hold", {127'd0, mem_busywait}, 128'd1);
                check("rdata_stable", mem_readdata, old);
            end
        end
        mem_read  = hold ? rd : 1'b0;
        mem_write = hold ? wr : 1'b0;
        mem_address = a;
        #1 check("busy_done", {127'd0, mem_busywait}, 128'd0);
        check("rdata_done", mem_readdata, ref_rdata);
        @(negedge clk);
        mem_read = 1'b0; mem_write = 1'b0;
        @(posedge clk);
        #1 check("busy_idle", {127'd0, mem_busywait}, 128'd0);
        check("rdata_idle", mem_readdata, ref_rdata);
    endtask

    initial begin
        logic [127:0] blk2, blkx, rnd;
        logic [27:0]  a;
        int           op;

        for (int i = 0; i < int'(DEPTH); i++) ref_mem[i] = pattern(i);
        ref_rdata = '0;

        #1 reset = 1'b1;
        #1 reset = 1'b0;
        #1 check("rst_rdata", mem_readdata, 128'd0);
        check("rst_busy", {127'd0, mem_busywait}, 128'd0);

        // Aliased read of block 0x19 with the request held into DONE.
        txn(1'b1, 1'b0, 28'h8000019, '0, 1'b1, 1'b0);
        check("alias_read", mem_readdata, {32'd103, 32'd102, 32'd101, 32'd100});

        blk2 = 128'hDEADBEEF_CAFEF00D_12345678_00000001;
        txn(1'b0, 1'b1, 28'h0000002, blk2, 1'b0, 1'b0);
        txn(1'b1, 1'b0, 28'h0000002, '0, 1'b0, 1'b1);
        check("wr_then_rd", mem_readdata, blk2);

        blkx = {$urandom(), $urandom(), $urandom(), $urandom()};
        txn(1'b1, 1'b1, 28'h0000003, blkx, 1'b1, 1'b1);
        check("both_rdata_kept", mem_readdata, blk2);
        txn(1'b1, 1'b0, 28'h0000003, '0, 1'b0, 1'b0);
        check("both_wrote", mem_readdata, blkx);

        // Reset two edges into a write to block 5: write must be abandoned.
        @(negedge clk);
        mem_write = 1'b1; mem_address = 28'h0000005; mem_writedata = {4{32'hBAD0BAD0}};
        @(posedge clk);
        @(posedge clk);
        @(posedge clk);
        #1 reset = 1'b1; mem_write = 1'b0;
        #1 check("rst_mid_busy", {127'd0, mem_busywait}, 128'd0);
        check("rst_mid_rdata", mem_readdata, 128'd0);
        ref_rdata = '0;
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk);
        txn(1'b1, 1'b0, 28'h0000005, '0, 1'b0, 1'b0);
        check("rst_no_write", mem_readdata, {32'd23, 32'd22, 32'd21, 32'd20});

        for (int n = 0; n < 40; n++) begin
            a = 28'($urandom());
            a[7:0] = 8'($urandom_range(0, 15));
            rnd = {$urandom(), $urandom(), $urandom(), $urandom()};
            op = int'($urandom_range(0, 2));
            txn(op != 1, op != 0, a, rnd, 1'($urandom()), 1'($urandom()));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
